// File: rtl/cache_sim_wrapper_if.sv
// Word-bus interface between a cache frontend master and cache_sim_wrapper.
`timescale 1ns/1ps
interface cache_sim_wrapper_if #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
);
    localparam int WADDR_W = ADDR_W - $clog2(DATA_W / 8);

    logic                  req;
    logic [WADDR_W-1:0]    addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ack;

    modport master (output req, addr, wdata, wstrb, input rdata, ack);
    modport slave  (input req, addr, wdata, wstrb, output rdata, ack);
endinterface

// File: rtl/cache_sim_wrapper.sv
// Direct-mapped, write-through, no-write-allocate cache with a write-through
// FIFO and a behavioural backing memory; one word per line. The address MSB
// selects a small control/status space instead of memory.
`timescale 1ns/1ps
module cache_sim_wrapper #(
    parameter int ADDR_W        = 24,
    parameter int DATA_W        = 32,
    parameter int NLINES_W      = 4,
    parameter int WTBUF_DEPTH_W = 2,
    parameter int MEM_ADDR_W    = 10,
    parameter int MEM_LAT       = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cache_sim_wrapper_if.slave    bus,
    input  logic                  invalidate_in,
    output logic                  invalidate_out,
    input  logic                  wtb_empty_in,
    output logic                  wtb_empty_out
);
    localparam int STRB_W    = DATA_W / 8;
    localparam int WADDR_W   = ADDR_W - $clog2(STRB_W);
    localparam int TAG_W     = WADDR_W - 1 - NLINES_W;
    localparam int NLINES    = 1 << NLINES_W;
    localparam int DEPTH     = 1 << WTBUF_DEPTH_W;
    localparam int MEM_WORDS = 1 << MEM_ADDR_W;
    localparam int CNT_W     = WTBUF_DEPTH_W + 1;
    localparam int LAT_W     = $clog2(MEM_LAT + 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_DRAIN, MEM_READ, ACK} state_t;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_w[8*b +: 8];
        end
        return res;
    endfunction

    state_t               state_q;
    logic [WADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 ack_q;
    logic [DATA_W-1:0]    rdata_q;
    logic                 inv_q;
    logic [LAT_W-1:0]     rd_cnt_q;
    logic [NLINES-1:0]    valid_q;
    logic [TAG_W-1:0]     tag_q  [NLINES];
    logic [DATA_W-1:0]    line_q [NLINES];

    // Backing store is deliberately outside the reset domain so rst_i keeps its contents.
    logic [DATA_W-1:0]    mem_q  [MEM_WORDS];

    logic [MEM_ADDR_W-1:0]    wb_addr_q [DEPTH];
    logic [DATA_W-1:0]        wb_data_q [DEPTH];
    logic [STRB_W-1:0]        wb_strb_q [DEPTH];
    logic [WTBUF_DEPTH_W-1:0] wb_wptr_q, wb_rptr_q;
    logic [CNT_W-1:0]         wb_cnt_q, wb_cnt_d;
    logic [LAT_W-1:0]         drain_cnt_q;

    logic [NLINES_W-1:0]   idx;
    logic [TAG_W-1:0]      tag;
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic [WADDR_W-2:0]    ctrl_word;
    logic                  is_ctrl, is_wr, hit, wb_full, wb_empty;
    logic                  push, pop, fill, line_we, inv_now;
    logic [DATA_W-1:0]     mem_rd, line_wd, ctrl_rd;

    assign bus.ack        = ack_q;
    assign bus.rdata      = rdata_q;
    assign invalidate_out = inv_q;
    assign wtb_empty_out  = wb_empty & wtb_empty_in;

    // Decode the registered request and derive cache/buffer strobes.
    always_comb begin
        idx       = addr_q[NLINES_W-1:0];
        tag       = addr_q[WADDR_W-2:NLINES_W];
        is_ctrl   = addr_q[WADDR_W-1];
        ctrl_word = addr_q[WADDR_W-2:0];
        mem_idx   = addr_q[MEM_ADDR_W-1:0];
        is_wr     = |wstrb_q;
        hit       = valid_q[idx] && (tag_q[idx] == tag);
        wb_full   = (wb_cnt_q == CNT_W'(DEPTH));
        wb_empty  = (wb_cnt_q == '0);
        push      = (state_q == LOOKUP) && !is_ctrl && is_wr && !wb_full;
        pop       = !wb_empty && (drain_cnt_q == LAT_W'(MEM_LAT - 1));
        fill      = (state_q == MEM_READ) && (rd_cnt_q == LAT_W'(MEM_LAT - 1));
        mem_rd    = mem_q[mem_idx];
        line_we   = fill || (push && hit);
        line_wd   = fill ? mem_rd : merge(line_q[idx], wdata_q, wstrb_q);
        inv_now   = invalidate_in || ((state_q == LOOKUP) && is_ctrl && is_wr);
        wb_cnt_d  = wb_cnt_q + CNT_W'(push) - CNT_W'(pop);
        ctrl_rd   = '0;
        if (ctrl_word == '0)                  ctrl_rd[0] = wtb_empty_out;
        else if (ctrl_word == (WADDR_W-1)'(1)) ctrl_rd[0] = wb_full;
    end

    // Request FSM with registered ack/rdata, plus valid-bit maintenance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
            inv_q    <= 1'b0;
            rd_cnt_q <= '0;
            valid_q  <= '0;
        end else begin
            inv_q <= inv_now;
            case (state_q)
                IDLE: begin
                    if (bus.req && !ack_q) begin
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        wstrb_q <= bus.wstrb;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (is_ctrl) begin
                        ack_q   <= 1'b1;
                        rdata_q <= is_wr ? '0 : ctrl_rd;
                        state_q <= ACK;
                    end else if (is_wr) begin
                        if (!wb_full) begin
                            ack_q   <= 1'b1;
                            rdata_q <= '0;
                            state_q <= ACK;
                        end
                    end else if (hit) begin
                        ack_q   <= 1'b1;
                        rdata_q <= line_q[idx];
                        state_q <= ACK;
                    end else if (wb_empty) begin
                        rd_cnt_q <= '0;
                        state_q  <= MEM_READ;
                    end else begin
                        state_q <= WAIT_DRAIN;
                    end
                end
                WAIT_DRAIN: begin
                    if (wb_empty) begin
                        rd_cnt_q <= '0;
                        state_q  <= MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (fill) begin
                        ack_q   <= 1'b1;
                        rdata_q <= mem_rd;
                        state_q <= ACK;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (fill) valid_q[idx] <= 1'b1;
            // Placed after the fill so a coincident invalidation leaves the line invalid.
            if (inv_now) valid_q <= '0;
        end
    end

    // Line data and tag arrays; validity lives in valid_q.
    always_ff @(posedge clk_i) begin
        if (line_we) begin
            line_q[idx] <= line_wd;
            tag_q[idx]  <= tag;
        end
    end

    // Write-buffer pointers, occupancy and drain pacing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_wptr_q   <= '0;
            wb_rptr_q   <= '0;
            wb_cnt_q    <= '0;
            drain_cnt_q <= '0;
        end else begin
            if (push) wb_wptr_q <= wb_wptr_q + 1'b1;
            if (pop)  wb_rptr_q <= wb_rptr_q + 1'b1;
            wb_cnt_q <= wb_cnt_d;
            if (wb_empty || pop) drain_cnt_q <= '0;
            else                 drain_cnt_q <= drain_cnt_q + 1'b1;
        end
    end

    // Write-buffer storage and byte-merged drain into the backing memory.
    always_ff @(posedge clk_i) begin
        if (push) begin
            wb_addr_q[wb_wptr_q] <= mem_idx;
            wb_data_q[wb_wptr_q] <= wdata_q;
            wb_strb_q[wb_wptr_q] <= wstrb_q;
        end
        if (pop) begin
            mem_q[wb_addr_q[wb_rptr_q]] <= merge(mem_q[wb_addr_q[wb_rptr_q]],
                                                 wb_data_q[wb_rptr_q],
                                                 wb_strb_q[wb_rptr_q]);
        end
    end
endmodule

// File: tb/tb_cache_sim_wrapper.sv
// Self-checking bench for cache_sim_wrapper: a vector table applied through a
// scoreboarded transaction task, then hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_cache_sim_wrapper;
    localparam int ADDR_W   = 24;
    localparam int DATA_W   = 32;
    localparam int AW       = ADDR_W - 2;
    localparam int MEM_LAT  = 16;
    localparam int MISS_LAT = 1 + MEM_LAT;
    localparam logic [AW-1:0] CTRL = {1'b1, {(AW-1){1'b0}}};

    logic clk = 1'b0;
    logic rst;
    logic invalidate_in, invalidate_out, wtb_empty_in, wtb_empty_out;

    cache_sim_wrapper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_sim_wrapper #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NLINES_W(4), .WTBUF_DEPTH_W(2),
        .MEM_ADDR_W(10), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .invalidate_in(invalidate_in), .invalidate_out(invalidate_out),
        .wtb_empty_in(wtb_empty_in), .wtb_empty_out(wtb_empty_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int last_lat = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        int          lat;   // negative: latency not pinned
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    wstrb;
        bit            settle;
        logic [31:0]   exp_rd;
        int            exp_lat;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] ws,
                                input bit st, input logic [31:0] er, input int el);
        vec_t v;
        v.addr = a; v.wdata = wd; v.wstrb = ws; v.settle = st; v.exp_rd = er; v.exp_lat = el;
        vecs.push_back(v);
    endfunction

    task automatic run(input string name, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = exp_rd;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        @(posedge clk); #1;
        bus.req = 1'b1; bus.addr = a; bus.wdata = wd; bus.wstrb = ws;
        n = 0; got = 1'b0;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            n++;
            if (bus.ack) got = 1'b1;
        end
        bus.req = 1'b0; bus.wstrb = '0;
        e = sb_q.pop_front();
        last_lat = n - 1;
        check($sformatf("%s ack", name), bus.ack, 1);
        if (!got) return;
        check($sformatf("%s rdata", name), bus.rdata, e.rdata);
        if (e.lat >= 0) check($sformatf("%s latency", name), last_lat, e.lat);
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (!wtb_empty_out && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("%s drain", name), wtb_empty_out, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        rst = 1'b1;
        bus.req = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
        invalidate_in = 1'b0; wtb_empty_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ack", bus.ack, 0);
        check("reset rdata", bus.rdata, 0);
        check("reset invalidate_out", invalidate_out, 0);
        check("reset wtb_empty_out", wtb_empty_out, 1);
        wtb_empty_in = 1'b0; #1;
        check("wtb_empty_in gating", wtb_empty_out, 0);
        wtb_empty_in = 1'b1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) add(AW'(i), 32'(i * 3), 4'hF, 1, 0, 1);
        for (int i = 0; i < 5; i++) add(AW'(i), 0, 4'h0, 1, 32'(i * 3), MISS_LAT);
        add(2,  0,            4'h0,    0, 6,            1);
        add(7,  32'h11223344, 4'hF,    1, 0,            1);
        add(7,  32'h0000AA00, 4'b0010, 0, 0,            1);
        add(7,  0,            4'h0,    0, 32'h1122AA44, -1);
        add(7,  0,            4'h0,    0, 32'h1122AA44, 1);
        add(2,  32'h000000FF, 4'b0001, 0, 0,            1);
        add(2,  0,            4'h0,    0, 32'hFF,       1);
        add(18, 32'h55,       4'hF,    1, 0,            1);
        add(2,  0,            4'h0,    0, 32'hFF,       1);
        add(18, 0,            4'h0,    1, 32'h55,       MISS_LAT);
        add(2,  0,            4'h0,    1, 32'hFF,       MISS_LAT);
        add(CTRL | AW'(0), 0, 4'h0,    1, 1,            1);
        add(CTRL | AW'(1), 0, 4'h0,    0, 0,            1);
        add(CTRL | AW'(5), 0, 4'h0,    0, 0,            1);

        foreach (vecs[i]) begin
            if (vecs[i].settle) wait_empty($sformatf("vec%0d", i));
            run($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
                vecs[i].exp_rd, vecs[i].exp_lat);
        end

        // Status word 0 also reflects the downstream empty flag.
        wtb_empty_in = 1'b0;
        run("ctrl0 downstream busy", CTRL, 0, 4'h0, 0, 1);
        wtb_empty_in = 1'b1;

        // Back-to-back writes fill the buffer; the 5th and 6th must stall.
        wait_empty("prefill");
        for (int i = 0; i < 6; i++) begin
            run($sformatf("burst wr%0d", i), AW'(32 + i), 32'(32'h100 + i), 4'hF, 0, -1);
            if (i < 4) check($sformatf("burst wr%0d latency", i), last_lat, 1);
            else       check($sformatf("burst wr%0d stalled", i), last_lat > 1, 1);
        end
        check("full wtb_empty_out", wtb_empty_out, 0);
        run("ctrl1 while full", CTRL | AW'(1), 0, 4'h0, 1, 1);
        run("ctrl0 while full", CTRL | AW'(0), 0, 4'h0, 0, 1);
        wait_empty("after burst");
        run("ctrl0 after drain", CTRL | AW'(0), 0, 4'h0, 1, 1);
        run("burst readback", AW'(37), 0, 4'h0, 32'h105, MISS_LAT);

        // External invalidation pulse.
        run("rd3 hit", 3, 0, 4'h0, 9, 1);
        @(posedge clk); #1;
        check("invalidate_out idle", invalidate_out, 0);
        invalidate_in = 1'b1;
        @(posedge clk); #1;
        check("invalidate_out pulse", invalidate_out, 1);
        invalidate_in = 1'b0;
        @(posedge clk); #1;
        check("invalidate_out drop", invalidate_out, 0);
        run("rd3 after invalidate", 3, 0, 4'h0, 9, MISS_LAT);

        // Ctrl-space write invalidates everything.
        run("rd3 hit again", 3, 0, 4'h0, 9, 1);
        run("ctrl write", CTRL, 0, 4'hF, 0, 1);
        check("ctrl write invalidate_out", invalidate_out, 1);
        run("rd3 after ctrl write", 3, 0, 4'h0, 9, MISS_LAT);

        // Invalidation held across a fill: data correct, line left invalid.
        invalidate_in = 1'b1;
        run("rd4 fill under invalidate", 4, 0, 4'h0, 12, MISS_LAT);
        invalidate_in = 1'b0;
        run("rd4 line still invalid", 4, 0, 4'h0, 12, MISS_LAT);
        run("rd4 hit", 4, 0, 4'h0, 12, 1);

        // Reset during the ack cycle clears outputs asynchronously.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.addr = 4; bus.wstrb = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre-reset ack", bus.ack, 1);
        check("pre-reset rdata", bus.rdata, 12);
        rst = 1'b1; #1;
        check("async reset ack", bus.ack, 0);
        check("async reset rdata", bus.rdata, 0);
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a miss: the aborted request never acks.
        @(posedge clk); #1;
        bus.req = 1'b1; bus.addr = 5; bus.wstrb = '0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; #1;
        check("mid-miss reset ack", bus.ack, 0);
        bus.req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        acks = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ack) acks++;
        end
        check("aborted miss no ack", acks, 0);
        run("rd4 after reset", 4, 0, 4'h0, 12, MISS_LAT);

        // A buffered write not yet drained is lost on reset.
        wait_empty("pre lost write");
        run("wr9 first", 9, 32'h111, 4'hF, 0, 1);
        wait_empty("wr9 drained");
        run("wr9 second", 9, 32'h222, 4'hF, 0, 1);
        rst = 1'b1; #1;
        check("reset empties buffer", wtb_empty_out, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run("rd9 after lost write", 9, 0, 4'h0, 32'h111, MISS_LAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
